// File: rtl/wb_scoreboard_pkg.sv
// Shared definitions for the writeback/scoreboard slice: default widths,
// the hard-wired zero register index and the register index type.
package wb_scoreboard_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Issue, ALU/LSU result and register-file write bundle between execute and
// writeback. The slave side is the writeback stage.
interface wb_scoreboard_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                     issue_valid;
  logic                     issue_load;
  logic [ADDR_WIDTH-1:0]    issue_rd;
  logic [ADDR_WIDTH-1:0]    issue_rs1;
  logic [ADDR_WIDTH-1:0]    issue_rs2;
  logic                     issue_ready;
  logic                     alu_valid;
  logic [ADDR_WIDTH-1:0]    alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     lsu_valid;
  logic                     lsu_ready;
  logic [ADDR_WIDTH-1:0]    lsu_rd;
  logic [DATA_WIDTH-1:0]    lsu_data;
  logic                     wen;
  logic [ADDR_WIDTH-1:0]    waddr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [2**ADDR_WIDTH-1:0] busy;

  modport slave (
    input  issue_valid, issue_load, issue_rd, issue_rs1, issue_rs2,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output issue_ready, lsu_ready, wen, waddr, wdata, busy
  );

  modport master (
    output issue_valid, issue_load, issue_rd, issue_rs1, issue_rs2,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, lsu_ready, wen, waddr, wdata, busy
  );
endinterface

// File: rtl/wb_busy_table.sv
// Busy-bit table: one bit per architectural register marking a load in
// flight, with one set port, one clear port and three lookup ports.
module wb_busy_table #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_set_en,
  input  logic [ADDR_WIDTH-1:0]    i_set_idx,
  input  logic                     i_clr_en,
  input  logic [ADDR_WIDTH-1:0]    i_clr_idx,
  input  logic [ADDR_WIDTH-1:0]    i_rs1_idx,
  input  logic [ADDR_WIDTH-1:0]    i_rs2_idx,
  input  logic [ADDR_WIDTH-1:0]    i_rd_idx,
  output logic                     o_rs1_busy,
  output logic                     o_rs2_busy,
  output logic                     o_rd_busy,
  output logic [2**ADDR_WIDTH-1:0] o_busy
);

  logic [2**ADDR_WIDTH-1:0] r_busy;
  logic [2**ADDR_WIDTH-1:0] w_busy_next;

  // Clear is applied before set so a colliding set wins; bit 0 is forced low.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_en) w_busy_next[i_clr_idx] = 1'b0;
    if (i_set_en) w_busy_next[i_set_idx] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign o_rs1_busy = r_busy[i_rs1_idx];
  assign o_rs2_busy = r_busy[i_rs2_idx];
  assign o_rd_busy  = r_busy[i_rd_idx];
  assign o_busy     = r_busy;

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback stage: arbitrates ALU (priority) and load results onto one
// registered regfile write port and stalls issue on load RAW/WAW hazards.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic           clk,
  input  logic           rst,
  wb_scoreboard_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] W_REG_ZERO = ADDR_WIDTH'(REG_ZERO);

  logic [CNT_W-1:0]      r_count;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_rs1_busy, w_rs2_busy, w_rd_busy;
  logic w_full, w_issue_ready, w_lsu_ready;
  logic w_issue_load_acc, w_lsu_acc, w_set_en, w_dec;

  assign w_full           = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_issue_ready    = !(w_rs1_busy || w_rs2_busy || w_rd_busy ||
                              (bus.issue_load && w_full));
  assign w_lsu_ready      = !bus.alu_valid;
  assign w_issue_load_acc = bus.issue_valid && w_issue_ready && bus.issue_load;
  assign w_lsu_acc        = bus.lsu_valid && w_lsu_ready;
  assign w_set_en         = w_issue_load_acc && (bus.issue_rd != W_REG_ZERO);
  // Results returning after a reset find count==0 and must not underflow it.
  assign w_dec            = w_lsu_acc && (r_count != '0);

  wb_busy_table #(.ADDR_WIDTH(ADDR_WIDTH)) u_busy (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_set_en),
    .i_set_idx  (bus.issue_rd),
    .i_clr_en   (w_lsu_acc),
    .i_clr_idx  (bus.lsu_rd),
    .i_rs1_idx  (bus.issue_rs1),
    .i_rs2_idx  (bus.issue_rs2),
    .i_rd_idx   (bus.issue_rd),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_rd_busy  (w_rd_busy),
    .o_busy     (bus.busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_issue_load_acc && !w_dec) begin
      r_count <= r_count + 1'b1;
    end else if (w_dec && !w_issue_load_acc) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (bus.alu_valid) begin
      r_wen   <= (bus.alu_rd != W_REG_ZERO);
      r_waddr <= bus.alu_rd;
      r_wdata <= bus.alu_data;
    end else if (bus.lsu_valid) begin
      r_wen   <= (bus.lsu_rd != W_REG_ZERO);
      r_waddr <= bus.lsu_rd;
      r_wdata <= bus.lsu_data;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign bus.issue_ready = w_issue_ready;
  assign bus.lsu_ready   = w_lsu_ready;
  assign bus.wen         = r_wen;
  assign bus.waddr       = r_waddr;
  assign bus.wdata       = r_wdata;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: expected writes are queued as stimulus is
// driven and popped after each clock edge; busy/ready follow a small model.
module tb_wb_scoreboard;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_scoreboard #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          rst;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] m_busy;
  int          m_count;
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    return !(m_busy[bus.issue_rs1] || m_busy[bus.issue_rs2] || m_busy[bus.issue_rd] ||
             (bus.issue_load && m_count == MAXO));
  endfunction

  // One clock: check combinational handshakes, advance the model, queue the
  // expected write, then compare registered outputs after the edge.
  task automatic tick();
    wr_t  e;
    logic rdy, acc_load, lsu_acc, dec;
    #1;
    if (!rst) begin
      chk("issue_ready", bus.issue_ready, model_ready());
      chk("lsu_ready", bus.lsu_ready, !bus.alu_valid);
    end
    e.rst = rst; e.wen = 1'b0; e.addr = '0; e.data = '0;
    if (rst) begin
      m_busy  = '0;
      m_count = 0;
    end else begin
      rdy      = model_ready();
      acc_load = bus.issue_valid && rdy && bus.issue_load;
      lsu_acc  = bus.lsu_valid && !bus.alu_valid;
      dec      = lsu_acc && (m_count != 0);
      if (bus.alu_valid) begin
        e.wen = (bus.alu_rd != 0); e.addr = bus.alu_rd; e.data = bus.alu_data;
      end else if (bus.lsu_valid) begin
        e.wen = (bus.lsu_rd != 0); e.addr = bus.lsu_rd; e.data = bus.lsu_data;
      end
      if (lsu_acc) m_busy[bus.lsu_rd] = 1'b0;
      if (acc_load && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
      if (acc_load && !dec)      m_count++;
      else if (dec && !acc_load) m_count--;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("wen", bus.wen, e.wen);
    if (e.wen || e.rst) begin
      chk("waddr", bus.waddr, e.addr);
      chk("wdata", bus.wdata, e.data);
    end
    chk("busy", bus.busy, m_busy);
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_load = 1'b0;
    bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic issue(input logic ld, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bus.issue_valid = 1'b1; bus.issue_load = ld;
    bus.issue_rd = rd; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
  endtask

  initial begin
    m_busy = '0; m_count = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and readiness
    issue(1'b0, 5'd3, 5'd1, 5'd2);
    #1;
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_lsu_ready", bus.lsu_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wen", bus.wen, 0);
    tick();
    idle();

    // Single ALU write visible for exactly one cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    chk("alu_wen", bus.wen, 1);
    chk("alu_waddr", bus.waddr, 5);
    chk("alu_wdata", bus.wdata, 32'hDEADBEEF);
    idle();
    tick();
    chk("alu_wen_drop", bus.wen, 0);

    // RAW stall on a pending load, released the cycle after its result
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    chk("raw_busy7_set", bus.busy[7], 1);
    issue(1'b0, 5'd8, 5'd7, 5'd0);
    #1;
    chk("raw_stall", bus.issue_ready, 0);
    tick();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0077;
    #1;
    chk("raw_stall_same_cycle", bus.issue_ready, 0);
    tick();
    chk("raw_ld_wen", bus.wen, 1);
    chk("raw_ld_waddr", bus.waddr, 7);
    chk("raw_ld_wdata", bus.wdata, 32'h0000_0077);
    chk("raw_busy7_clr", bus.busy[7], 0);
    bus.lsu_valid = 1'b0;
    #1;
    chk("raw_ready_after", bus.issue_ready, 1);
    tick();
    idle();

    // ALU beats load in the same cycle; load lands one cycle later
    issue(1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3333_3333;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h4444_4444;
    #1;
    chk("arb_lsu_blocked", bus.lsu_ready, 0);
    tick();
    chk("arb_alu_waddr", bus.waddr, 3);
    bus.alu_valid = 1'b0;
    #1;
    chk("arb_lsu_ready", bus.lsu_ready, 1);
    tick();
    chk("arb_ld_waddr", bus.waddr, 4);
    chk("arb_ld_wdata", bus.wdata, 32'h4444_4444);
    idle();
    tick();

    // Outstanding limit
    for (int unsigned i = 1; i <= 4; i++) begin
      issue(1'b1, AW'(i), 5'd0, 5'd0);
      tick();
    end
    issue(1'b1, 5'd5, 5'd0, 5'd0);
    #1;
    chk("lim_5th_stall", bus.issue_ready, 0);
    issue(1'b0, 5'd9, 5'd0, 5'd0);
    #1;
    chk("lim_alu_ready", bus.issue_ready, 1);
    issue(1'b1, 5'd5, 5'd0, 5'd0);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd1; bus.lsu_data = 32'h0000_1111;
    #1;
    chk("lim_stall_on_return", bus.issue_ready, 0);
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    chk("lim_5th_ready", bus.issue_ready, 1);
    tick();
    chk("lim_busy5", bus.busy[5], 1);
    idle();
    for (int unsigned i = 2; i <= 5; i++) begin
      bus.lsu_valid = 1'b1; bus.lsu_rd = AW'(i); bus.lsu_data = 32'hA000_0000 + i;
      tick();
    end
    idle();
    tick();
    chk("lim_drained", bus.busy, 0);

    // x0 writes and loads
    issue(1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    chk("x0_busy0", bus.busy[0], 0);
    idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hFFFF_FFFF;
    tick();
    chk("x0_ld_wen", bus.wen, 0);
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234_5678;
    tick();
    chk("x0_alu_wen", bus.wen, 0);
    idle();

    // Reset with two loads pending
    issue(1'b1, 5'd20, 5'd0, 5'd0);
    tick();
    issue(1'b1, 5'd21, 5'd0, 5'd0);
    tick();
    chk("pre_rst_busy", bus.busy, 32'h0030_0000);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(1'b1, 5'd22, 5'd20, 5'd21);
    #1;
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_ready", bus.issue_ready, 1);
    idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd20; bus.lsu_data = 32'h0000_2020;
    tick();
    chk("stale_ld_wen", bus.wen, 1);
    bus.lsu_rd = 5'd21; bus.lsu_data = 32'h0000_2121;
    tick();
    idle();
    // Count must not have wrapped below zero: exactly four loads fit again
    for (int unsigned i = 10; i <= 13; i++) begin
      issue(1'b1, AW'(i), 5'd0, 5'd0);
      tick();
    end
    issue(1'b1, 5'd14, 5'd0, 5'd0);
    #1;
    chk("post_rst_limit", bus.issue_ready, 0);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
